// File: rtl/tcp_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcp_rx_pkg : shared parser state encoding, error codes, default header   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package tcp_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } rx_state_t;

    localparam logic [1:0] c_ERR_NONE = 2'b00;
    localparam logic [1:0] c_ERR_SYNC = 2'b01;
    localparam logic [1:0] c_ERR_SEQ  = 2'b10;
    localparam logic [1:0] c_ERR_CSUM = 2'b11;

    localparam logic [7:0] c_HDR_BYTE_DEF = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/tcp_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcp_rx_fifo : single-clock byte FIFO with synchronous flush and count    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tcp_rx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [7:0]    r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Count never exceeds the depth, so its MSB alone marks "full".
    assign o_full    = r_count[AW];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_pop_ok  = i_pop && !o_empty && !i_flush;
    assign w_push_ok = i_push && (!o_full || w_pop_ok) && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/tcp_rx_frame_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcp_rx_frame_checker : SiTCP RX frame parser with seq/checksum stats     |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
module tcp_rx_frame_checker
    import tcp_rx_pkg::*;
#(
    parameter int         FIFO_AW  = 4,
    parameter logic [7:0] HDR_BYTE = c_HDR_BYTE_DEF
) (
    input  logic        SystemClk,
    input  logic        SystemRstBar,
    input  logic        TCP_OPEN_ACK,
    input  logic        TCP_RX_WR,
    input  logic [7:0]  TCP_RX_DATA,
    output logic [15:0] TCP_RX_WC,
    input  logic        RegClrTrg,
    input  logic        RegStallEnb,
    output logic [31:0] FrameCount,
    output logic [15:0] ErrCount,
    output logic        OvfFlag,
    output logic [1:0]  LastErr
);

    logic [7:0]      w_byte;
    logic            w_full;
    logic            w_empty;
    logic [FIFO_AW:0] w_count;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf;

    rx_state_t       r_state, w_state_nxt;
    logic [7:0]      r_remain, w_remain_nxt;
    logic [7:0]      r_csum, w_csum_nxt;
    logic            r_frame_err, w_frame_err_nxt;
    logic [7:0]      r_exp_seq, w_exp_seq_nxt;

    logic            w_frame_done;
    logic            w_err_inc;
    logic [1:0]      w_err_code;

    logic [31:0]     r_frame_cnt;
    logic [15:0]     r_err_cnt;
    logic            r_ovf;
    logic [1:0]      r_last_err;

    assign w_pop  = !w_empty && !RegStallEnb && TCP_OPEN_ACK;
    assign w_push = TCP_RX_WR && TCP_OPEN_ACK;
    // A full FIFO still takes the byte when a pop frees a slot this cycle.
    assign w_ovf  = TCP_RX_WR && TCP_OPEN_ACK && w_full && !w_pop;

    tcp_rx_fifo #(
        .AW      (FIFO_AW)
    ) u_fifo (
        .clk     (SystemClk),
        .rst_n   (SystemRstBar),
        .i_flush (!TCP_OPEN_ACK),
        .i_push  (w_push),
        .i_data  (TCP_RX_DATA),
        .i_pop   (w_pop),
        .o_data  (w_byte),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign TCP_RX_WC = 16'(w_count);

    always_ff @(posedge SystemClk or negedge SystemRstBar) begin
        if (!SystemRstBar) r_state <= ST_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remain_nxt    = r_remain;
        w_csum_nxt      = r_csum;
        w_frame_err_nxt = r_frame_err;
        w_exp_seq_nxt   = r_exp_seq;
        w_frame_done    = 1'b0;
        w_err_inc       = 1'b0;
        w_err_code      = c_ERR_NONE;
        if (!TCP_OPEN_ACK) begin
            w_state_nxt   = ST_IDLE;
            w_exp_seq_nxt = '0;
        end else if (w_pop) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == HDR_BYTE) begin
                        w_state_nxt = ST_LEN;
                    end else begin
                        w_err_inc  = 1'b1;
                        w_err_code = c_ERR_SYNC;
                    end
                end
                ST_LEN: begin
                    w_remain_nxt    = w_byte;
                    w_csum_nxt      = w_byte;
                    w_frame_err_nxt = 1'b0;
                    w_state_nxt     = (w_byte == 8'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    w_csum_nxt    = r_csum ^ w_byte;
                    if (w_byte != r_exp_seq) w_frame_err_nxt = 1'b1;
                    // Follow the stream so one gap costs exactly one errored frame.
                    w_exp_seq_nxt = w_byte + 8'd1;
                    w_remain_nxt  = r_remain - 8'd1;
                    if (r_remain == 8'd1) w_state_nxt = ST_CSUM;
                end
                ST_CSUM: begin
                    w_frame_done = 1'b1;
                    if (w_byte != r_csum) begin
                        w_err_inc  = 1'b1;
                        w_err_code = c_ERR_CSUM;
                    end else if (r_frame_err) begin
                        w_err_inc  = 1'b1;
                        w_err_code = c_ERR_SEQ;
                    end
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SystemClk or negedge SystemRstBar) begin
        if (!SystemRstBar) begin
            r_remain    <= '0;
            r_csum      <= '0;
            r_frame_err <= 1'b0;
            r_exp_seq   <= '0;
        end else begin
            r_remain    <= w_remain_nxt;
            r_csum      <= w_csum_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_exp_seq   <= w_exp_seq_nxt;
        end
    end

    always_ff @(posedge SystemClk or negedge SystemRstBar) begin
        if (!SystemRstBar) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_last_err  <= c_ERR_NONE;
        end else if (RegClrTrg) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_last_err  <= c_ERR_NONE;
        end else begin
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 32'd1;
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
            if (w_err_inc) r_last_err <= w_err_code;
            if (w_ovf) r_ovf <= 1'b1;
        end
    end

    assign FrameCount = r_frame_cnt;
    assign ErrCount   = r_err_cnt;
    assign OvfFlag    = r_ovf;
    assign LastErr    = r_last_err;

endmodule
`default_nettype wire

// File: tb/tb_tcp_rx_frame_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tcp_rx_frame_checker : directed + random frames vs frame-level model  |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_tcp_rx_frame_checker;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        SystemRstBar;
    logic        TCP_OPEN_ACK;
    logic        TCP_RX_WR;
    logic [7:0]  TCP_RX_DATA;
    logic [15:0] TCP_RX_WC;
    logic        RegClrTrg;
    logic        RegStallEnb;
    logic [31:0] FrameCount;
    logic [15:0] ErrCount;
    logic        OvfFlag;
    logic [1:0]  LastErr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  m_fifo[$];
    logic [7:0]  m_frame[$];
    logic [7:0]  m_exp;
    logic [31:0] m_fc;
    logic [15:0] m_ec;
    logic        m_ovf;
    logic [1:0]  m_le;
    logic [7:0]  tx_seq;

    always #5 clk = ~clk;

    tcp_rx_frame_checker #(
        .FIFO_AW      (4),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .SystemClk    (clk),
        .SystemRstBar (SystemRstBar),
        .TCP_OPEN_ACK (TCP_OPEN_ACK),
        .TCP_RX_WR    (TCP_RX_WR),
        .TCP_RX_DATA  (TCP_RX_DATA),
        .TCP_RX_WC    (TCP_RX_WC),
        .RegClrTrg    (RegClrTrg),
        .RegStallEnb  (RegStallEnb),
        .FrameCount   (FrameCount),
        .ErrCount     (ErrCount),
        .OvfFlag      (OvfFlag),
        .LastErr      (LastErr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_frame.delete();
        m_exp = '0;
        m_fc  = '0;
        m_ec  = '0;
        m_ovf = 1'b0;
        m_le  = 2'b00;
    endtask

    // Collects a whole frame, then judges it in one pass.
    function automatic void feed(input logic [7:0] b, output bit done, output bit inc,
                                 output logic [1:0] code);
        int         n;
        logic [7:0] cs;
        bit         seqbad;
        done = 1'b0;
        inc  = 1'b0;
        code = 2'b00;
        if (m_frame.size() == 0) begin
            if (b == 8'hA5) m_frame.push_back(b);
            else begin
                inc  = 1'b1;
                code = 2'b01;
            end
        end else begin
            m_frame.push_back(b);
            if (m_frame.size() >= 2 && m_frame.size() == int'(m_frame[1]) + 3) begin
                n      = int'(m_frame[1]);
                cs     = m_frame[1];
                seqbad = 1'b0;
                for (int i = 0; i < n; i++) begin
                    cs = cs ^ m_frame[2+i];
                    if (m_frame[2+i] != m_exp) seqbad = 1'b1;
                    m_exp = m_frame[2+i] + 8'd1;
                end
                done = 1'b1;
                if (m_frame[n+2] != cs) begin
                    inc  = 1'b1;
                    code = 2'b11;
                end else if (seqbad) begin
                    inc  = 1'b1;
                    code = 2'b10;
                end
                m_frame.delete();
            end
        end
    endfunction

    task automatic cyc(input bit wr, input logic [7:0] d, input bit clr);
        bit         pop, full, done, inc, ovf_ev;
        logic [1:0] code;
        logic [7:0] b;
        TCP_RX_WR   = wr;
        TCP_RX_DATA = d;
        RegClrTrg   = clr;
        @(posedge clk);
        done = 1'b0; inc = 1'b0; code = 2'b00; ovf_ev = 1'b0;
        if (!TCP_OPEN_ACK) begin
            m_fifo.delete();
            m_frame.delete();
            m_exp = '0;
        end else begin
            pop  = (m_fifo.size() > 0) && !RegStallEnb;
            full = (m_fifo.size() == 16);
            if (pop) begin
                b = m_fifo.pop_front();
                feed(b, done, inc, code);
            end
            if (wr) begin
                if (!full || pop) m_fifo.push_back(d);
                else ovf_ev = 1'b1;
            end
        end
        if (clr) begin
            m_fc = '0; m_ec = '0; m_ovf = 1'b0; m_le = 2'b00;
        end else begin
            if (done) m_fc = m_fc + 32'd1;
            if (inc && m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
            if (inc) m_le = code;
            if (ovf_ev) m_ovf = 1'b1;
        end
        #1;
        chk("TCP_RX_WC", 32'(TCP_RX_WC), 32'(m_fifo.size()));
        chk("FrameCount", FrameCount, m_fc);
        chk("ErrCount", 32'(ErrCount), 32'(m_ec));
        chk("OvfFlag", 32'(OvfFlag), 32'(m_ovf));
        chk("LastErr", 32'(LastErr), 32'(m_le));
        TCP_RX_WR = 1'b0;
        RegClrTrg = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input bq_t q);
        foreach (q[i]) cyc(1'b1, q[i], 1'b0);
    endtask

    function automatic bq_t build_frame(input int n, input bit bad_seq, input bit bad_csum);
        bq_t        q;
        logic [7:0] cs, s;
        s  = bad_seq ? tx_seq + 8'd1 : tx_seq;
        cs = 8'(n);
        q.push_back(8'hA5);
        q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            q.push_back(s);
            cs = cs ^ s;
            s  = s + 8'd1;
        end
        tx_seq = s;
        q.push_back(bad_csum ? ~cs : cs);
        return q;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_WC"}, 32'(TCP_RX_WC), 32'd0);
        chk({tag, "_FrameCount"}, FrameCount, 32'd0);
        chk({tag, "_ErrCount"}, 32'(ErrCount), 32'd0);
        chk({tag, "_OvfFlag"}, 32'(OvfFlag), 32'd0);
        chk({tag, "_LastErr"}, 32'(LastErr), 32'd0);
    endtask

    initial begin
        bq_t        q;
        logic [7:0] g;
        SystemRstBar = 1'b1;
        TCP_OPEN_ACK = 1'b0;
        TCP_RX_WR    = 1'b0;
        TCP_RX_DATA  = 8'h00;
        RegClrTrg    = 1'b0;
        RegStallEnb  = 1'b0;
        tx_seq       = 8'h00;
        model_reset();

        #2 SystemRstBar = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        SystemRstBar = 1'b0;
        #2 SystemRstBar = 1'b1;
        TCP_OPEN_ACK = 1'b1;
        idle(2);

        q = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send(q);
        idle(3);
        chk("first_frame_count", FrameCount, 32'd1);
        chk("first_frame_err", 32'(ErrCount), 32'd0);
        chk("first_frame_lasterr", 32'(LastErr), 32'd0);
        chk("first_frame_wc", 32'(TCP_RX_WC), 32'd0);

        q = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'h03};  send(q);
        q = '{8'hA5, 8'h02, 8'h09, 8'h0A, 8'h03};  send(q);
        q = '{8'hA5, 8'h01, 8'h0B, 8'h0A};         send(q);
        idle(3);

        q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'hFF};  send(q);
        idle(3);
        q = '{8'h11, 8'h22, 8'h33};                send(q);
        tx_seq = m_exp;
        send(build_frame(3, 1'b0, 1'b0));
        idle(3);

        RegStallEnb = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("stall_wc_full", 32'(TCP_RX_WC), 32'd16);
        chk("stall_ovf", 32'(OvfFlag), 32'd1);
        RegStallEnb = 1'b0;
        idle(20);

        q = '{8'hA5, 8'h00, 8'h00};  send(q);
        idle(2);
        send(q);
        cyc(1'b0, 8'h00, 1'b1);
        chk("clr_vs_csum_fc", FrameCount, 32'd0);
        chk("clr_vs_csum_ec", 32'(ErrCount), 32'd0);
        idle(2);

        q = '{8'hA5, 8'h06, 8'h00, 8'h01, 8'h02};  send(q);
        idle(2);
        RegStallEnb = 1'b1;
        q = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07};  send(q);
        TCP_OPEN_ACK = 1'b0;
        cyc(1'b1, 8'h08, 1'b0);
        chk("close_flush_wc", 32'(TCP_RX_WC), 32'd0);
        TCP_OPEN_ACK = 1'b1;
        RegStallEnb  = 1'b0;
        q = '{8'hA5, 8'h01, 8'h00, 8'h01};  send(q);
        idle(3);

        q = '{8'hA5, 8'h03, 8'h00};  send(q);
        #2 SystemRstBar = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        #2 SystemRstBar = 1'b1;
        tx_seq = 8'h00;
        send(build_frame(2, 1'b0, 1'b0));
        idle(3);

        tx_seq = m_exp;
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 39) == 0) begin
                TCP_OPEN_ACK = 1'b0;
                cyc(1'b0, 8'h00, 1'b0);
                TCP_OPEN_ACK = 1'b1;
                tx_seq = 8'h00;
            end
            if ($urandom_range(0, 5) == 0) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                cyc(1'b1, g, 1'b0);
            end
            q = build_frame($urandom_range(0, 5), $urandom_range(0, 5) == 0,
                            $urandom_range(0, 5) == 0);
            foreach (q[i]) begin
                if ($urandom_range(0, 7) == 0) RegStallEnb = ~RegStallEnb;
                cyc(1'b1, q[i], $urandom_range(0, 31) == 0);
                if ($urandom_range(0, 3) == 0) cyc(1'b0, 8'h00, 1'b0);
            end
        end
        RegStallEnb = 1'b0;
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
